hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage pipelined core.
- Drives enable and flush for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and taken branches, and freezes the pipeline during multi-cycle data-memory accesses, with a timeout watchdog.
- Generates the EX-stage operand forwarding selects and a stall-cycle performance counter.

Parameters:
- TIMEOUT, 16: maximum data-memory wait cycles before error; 0 disables the watchdog.
- CNT_W, 32: width of the stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- id_rs1, id_rs2  in  5 each  source regs of the instruction in ID
- ex_rs1, ex_rs2  in  5 each  source regs held in ID/EX (instruction in EX)
- id_ex_rd  in  5  dest of the instruction in EX
- id_ex_mem_to_reg  in  1  instruction in EX is a load
- ex_mem_rd  in  5  dest in EX/MEM
- ex_mem_regwrite  in  1  EX/MEM writes regfile
- ex_mem_mem_req  in  1  instruction in MEM accesses data memory
- dmem_ack  in  1  data memory access completes this cycle
- mem_wb_rd  in  5  dest in MEM/WB
- mem_wb_regwrite  in  1  MEM/WB writes regfile
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- pc_en  out  1  PC update enable
- if_id_en, if_id_flush  out  1 each
- id_ex_en, id_ex_flush  out  1 each
- ex_mem_en, ex_mem_flush  out  1 each
- mem_wb_en, mem_wb_flush  out  1 each
- fwd_a, fwd_b  out  2 each  operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- mem_err  out  1  sticky watchdog error
- stall_count  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Reset (rst=0 at a clk edge): state=RUN, wait_cnt=0, mem_err=0, stall_count=0.
- While rst=0, combinational outputs are: all *_en=0, all *_flush=1, fwd_a=fwd_b=00.
- States: RUN, MEM_WAIT, ERR. Enables and flushes are combinational from state and inputs, so they take effect in the same cycle.
- Default in RUN with no event: all *_en=1, all *_flush=0.
- Memory freeze (highest priority):
  - Condition: (state=RUN and ex_mem_mem_req=1 and dmem_ack=0), or state=MEM_WAIT with dmem_ack=0.
  - Response: all *_en=0, all *_flush=0. MEM/WB is held; rewriting the same regfile value is idempotent and required.
  - RUN goes to MEM_WAIT at the next edge; wait_cnt is set to 1.
  - In MEM_WAIT, dmem_ack=1 gives the default enables that cycle and the state returns to RUN with wait_cnt=0.
  - In MEM_WAIT, dmem_ack=0 increments wait_cnt.
  - If TIMEOUT!=0 and wait_cnt=TIMEOUT with dmem_ack=0, go to ERR.
  - In RUN, ex_mem_mem_req=1 with dmem_ack=1 in the same cycle causes no stall.
- Taken branch (second priority, evaluated only when not frozen):
  - ex_branch_taken=1 gives pc_en=1, if_id_flush=1, id_ex_flush=1; all other en=1.
  - Any load-use hazard in the same cycle is ignored (wrong-path).
- Load-use stall (third priority):
  - Condition: id_ex_mem_to_reg=1, id_ex_rd!=0, and id_ex_rd equals id_rs1 or id_rs2.
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en and mem_wb_en stay 1.
  - Exactly one bubble per hazard, since the load leaves EX next cycle.
- ERR: all *_en=0, flush=0, mem_err=1. Exit only by reset.
- Forwarding (combinational, independent of state):
  - fwd_a=01 if ex_mem_regwrite, ex_mem_rd!=0 and ex_mem_rd=ex_rs1.
  - Else fwd_a=10 if mem_wb_regwrite, mem_wb_rd!=0 and mem_wb_rd=ex_rs1.
  - Else fwd_a=00.
  - fwd_b is identical using ex_rs2.
  - EX/MEM has priority because it is the newer value.
  - x0 is never forwarded.
- stall_count: increments at each edge where pc_en=0 and rst=1, including ERR; saturates at all-ones.

Test Plan:
- Load-use: id_ex_mem_to_reg=1, id_ex_rd=5, id_rs2=5 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; next cycle (hazard cleared) all en=1; stall_count=1.
- Taken branch with simultaneous load-use → pc_en=1, if_id_flush=1, id_ex_flush=1; no stall; stall_count unchanged.
- Memory wait: ex_mem_mem_req=1, dmem_ack low for 3 cycles then high → all en=0 for 3 cycles, en=1 on the ack cycle, state back to RUN, stall_count=3; a branch asserted during the wait takes effect only on the ack cycle.
- Timeout, TIMEOUT=4: dmem_ack never asserts → ERR entered after 4 wait cycles; mem_err=1 and stays 1 until rst=0; all en remain 0.
- Forwarding: ex_rs1=ex_rs2=7, EX/MEM rd=7 and MEM/WB rd=7 both writing → fwd_a=fwd_b=01; clear ex_mem_regwrite → 10; rd=0 → 00.
- Reset mid-MEM_WAIT: rst=0 for one edge → next cycle state=RUN, mem_err=0, stall_count=0; during rst=0, all flush=1 and all en=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes, load-use and branch handling, dmem freeze with watchdog, EX forwarding.
// Enables/flushes/forwarding are combinational; state, mem_err and stall_count update on the clk edge.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_to_reg,
    input  logic [4:0]       ex_mem_rd,
    input  logic             ex_mem_regwrite,
    input  logic             ex_mem_mem_req,
    input  logic             dmem_ack,
    input  logic [4:0]       mem_wb_rd,
    input  logic             mem_wb_regwrite,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_en,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]     state;
    logic [WCW-1:0] wait_cnt;
    logic           freeze;
    logic           load_use;
    logic           halted;

    assign freeze   = !dmem_ack && ((state == S_RUN && ex_mem_mem_req) || state == S_WAIT);
    assign load_use = id_ex_mem_to_reg && (id_ex_rd != 5'd0) &&
                      ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));
    // Any state other than RUN/MEM_WAIT (including the unused encoding) behaves as ERR.
    assign halted   = (state != S_RUN) && (state != S_WAIT);

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (halted || freeze) begin
            // MEM/WB is held too: re-writing the same regfile value is harmless.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // EX/MEM holds the newer result, so it wins over MEM/WB; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (ex_mem_regwrite && ex_mem_rd != 5'd0 && ex_mem_rd == rs)
            return 2'b01;
        else if (mem_wb_regwrite && mem_wb_rd != 5'd0 && mem_wb_rd == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst) begin
            fwd_a = fwd_sel(ex_rs1);
            fwd_b = fwd_sel(ex_rs2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_RUN;
            wait_cnt    <= '0;
            mem_err     <= 1'b0;
            stall_count <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (freeze) begin
                        state    <= S_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        state    <= S_RUN;
                        wait_cnt <= '0;
                    end else if (TIMEOUT != 0 && wait_cnt == WCW'(TIMEOUT)) begin
                        state   <= S_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                default: begin
                    state   <= S_ERR;
                    mem_err <= 1'b1;
                end
            endcase
            if (!pc_en && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4 and a 3-bit stall counter so saturation is reachable.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic       id_ex_mem_to_reg, ex_mem_regwrite, ex_mem_mem_req, dmem_ack;
    logic       mem_wb_regwrite, ex_branch_taken;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic       ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_err;
    logic [2:0] stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .ex_mem_mem_req(ex_mem_mem_req), .dmem_ack(dmem_ack),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
        .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_count(stall_count)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb} and {if_id, id_ex, ex_mem, mem_wb}
    wire [4:0] en_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    wire [3:0] fl_v = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; id_ex_rd = 0;
        ex_mem_rd = 0; mem_wb_rd = 0; id_ex_mem_to_reg = 0; ex_mem_regwrite = 0;
        ex_mem_mem_req = 0; dmem_ack = 0; mem_wb_regwrite = 0; ex_branch_taken = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        ex_rs1 = 7; ex_mem_rd = 7; ex_mem_regwrite = 1;
        #1;
        chk("rst_en", en_v, 5'b00000);
        chk("rst_flush", fl_v, 4'b1111);
        chk("rst_fwd_a", fwd_a, 2'b00);
        tick();
        chk("rst_sc", stall_count, 3'd0);
        chk("rst_err", mem_err, 1'b0);

        rst = 1'b1;
        clear_inputs();
        #1;
        chk("idle_en", en_v, 5'b11111);
        chk("idle_flush", fl_v, 4'b0000);

        // load-use on rs2
        id_ex_mem_to_reg = 1; id_ex_rd = 5; id_rs2 = 5;
        #1;
        chk("lu_en", en_v, 5'b00111);
        chk("lu_flush", fl_v, 4'b0100);
        tick();
        id_ex_mem_to_reg = 0;
        #1;
        chk("lu_after_en", en_v, 5'b11111);
        chk("lu_sc", stall_count, 3'd1);

        // load writing x0 is not a hazard
        id_ex_mem_to_reg = 1; id_ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        #1;
        chk("lu_x0_en", en_v, 5'b11111);
        tick();

        // branch overrides simultaneous load-use
        id_ex_rd = 5; id_rs1 = 5; ex_branch_taken = 1;
        #1;
        chk("br_en", en_v, 5'b11111);
        chk("br_flush", fl_v, 4'b1100);
        tick();
        chk("br_sc", stall_count, 3'd1);
        clear_inputs();

        // memory wait: 3 frozen cycles, branch raised mid-wait
        ex_mem_mem_req = 1; dmem_ack = 0;
        #1;
        chk("mw0_en", en_v, 5'b00000);
        chk("mw0_flush", fl_v, 4'b0000);
        tick();
        ex_branch_taken = 1;
        #1;
        chk("mw1_en", en_v, 5'b00000);
        chk("mw1_flush", fl_v, 4'b0000);
        tick();
        chk("mw2_en", en_v, 5'b00000);
        tick();
        dmem_ack = 1;
        #1;
        chk("mw_ack_en", en_v, 5'b11111);
        chk("mw_ack_flush", fl_v, 4'b1100);
        chk("mw_sc", stall_count, 3'd4);
        tick();
        ex_branch_taken = 0; ex_mem_mem_req = 0; dmem_ack = 0;
        #1;
        chk("mw_run_en", en_v, 5'b11111);
        chk("mw_sc_after", stall_count, 3'd4);

        // request acked in the same cycle: no stall
        ex_mem_mem_req = 1; dmem_ack = 1;
        #1;
        chk("ack_now_en", en_v, 5'b11111);
        tick();
        chk("ack_now_sc", stall_count, 3'd4);
        clear_inputs();

        // forwarding
        ex_rs1 = 7; ex_rs2 = 7; ex_mem_rd = 7; ex_mem_regwrite = 1; mem_wb_rd = 7; mem_wb_regwrite = 1;
        #1;
        chk("fwd_a_exmem", fwd_a, 2'b01);
        chk("fwd_b_exmem", fwd_b, 2'b01);
        ex_mem_regwrite = 0;
        #1;
        chk("fwd_a_memwb", fwd_a, 2'b10);
        chk("fwd_b_memwb", fwd_b, 2'b10);
        mem_wb_rd = 0;
        #1;
        chk("fwd_a_x0", fwd_a, 2'b00);
        ex_mem_regwrite = 1; ex_rs2 = 3; mem_wb_rd = 3;
        #1;
        chk("fwd_a_mix", fwd_a, 2'b01);
        chk("fwd_b_mix", fwd_b, 2'b10);
        ex_rs1 = 0; ex_mem_rd = 0;
        #1;
        chk("fwd_a_rs0", fwd_a, 2'b00);
        clear_inputs();

        // timeout: RUN freeze, then wait_cnt 1..4, then ERR
        ex_mem_mem_req = 1; dmem_ack = 0;
        tick();
        chk("to_sc5", stall_count, 3'd5);
        tick();
        tick();
        chk("to_sc7", stall_count, 3'd7);
        tick();
        chk("to_sat", stall_count, 3'd7);
        chk("to_no_err_yet", mem_err, 1'b0);
        chk("to_wait_en", en_v, 5'b00000);
        tick();
        chk("to_err", mem_err, 1'b1);
        dmem_ack = 1; ex_mem_mem_req = 0;
        #1;
        chk("err_en", en_v, 5'b00000);
        chk("err_flush", fl_v, 4'b0000);
        tick();
        chk("err_sticky", mem_err, 1'b1);
        chk("err_sc", stall_count, 3'd7);

        // reset out of ERR
        rst = 1'b0;
        #1;
        chk("rst2_flush", fl_v, 4'b1111);
        tick();
        rst = 1'b1; clear_inputs();
        #1;
        chk("rst2_err", mem_err, 1'b0);
        chk("rst2_sc", stall_count, 3'd0);
        chk("rst2_en", en_v, 5'b11111);

        // reset in the middle of MEM_WAIT
        ex_mem_mem_req = 1; dmem_ack = 0;
        tick();
        tick();
        chk("rmw_sc", stall_count, 3'd2);
        rst = 1'b0;
        #1;
        chk("rmw_rst_en", en_v, 5'b00000);
        chk("rmw_rst_flush", fl_v, 4'b1111);
        tick();
        rst = 1'b1; ex_mem_mem_req = 0;
        #1;
        chk("rmw_run_en", en_v, 5'b11111);
        chk("rmw_sc0", stall_count, 3'd0);
        chk("rmw_err0", mem_err, 1'b0);
        tick();
        chk("rmw_sc_hold", stall_count, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
